hwpe_stream_split_decoupled: RTL
================================

Name: hwpe_stream_split_decoupled

Overview:
- Splits one wide HWPE stream into NB_OUT_STREAMS narrow streams. Each output lane has its own FIFO, so the output lanes drain independently.
- The input handshake no longer needs every consumer ready in the same cycle.
- A per-lane enable mask allows lanes to be excluded from the split.
- Sits between streamers and engines where downstream consumers run with skewed backpressure.

Parameters:
- NB_OUT_STREAMS, 2: number of output lanes (>=1).
- DATA_WIDTH_IN, 128: input data width. Must be divisible by NB_OUT_STREAMS*8; elaboration-time assertion.
- FIFO_DEPTH, 2: entries per lane FIFO (>=1). Use 2 for full throughput.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- lane_en_i  in  NB_OUT_STREAMS  per-lane enable; sampled each cycle.
- stream_i  sink  DATA_WIDTH_IN data, DATA_WIDTH_IN/8 strb, valid, ready  wide input stream.
- stream_o[NB_OUT_STREAMS-1:0]  source  DW_OUT=DATA_WIDTH_IN/NB_OUT_STREAMS data, DW_OUT/8 strb, valid, ready  lane outputs.
- lane_empty_o  out  NB_OUT_STREAMS  per-lane FIFO empty flag.
- busy_o  out  1  OR of ~lane_empty_o.

Behaviour:
- Slicing: lane ii carries data[(ii+1)*DW_OUT-1 : ii*DW_OUT] and the matching strb slice, in order.
- Reset (rst_i=1 at clk edge): all FIFOs empty.
  - All stream_o.valid=0.
  - lane_empty_o = all ones.
  - busy_o=0.
  - stream_i.ready = 1 unless FIFO_DEPTH is 0 (illegal).
- Clear: identical effect to reset, one cycle. Priority is reset > clear > push/pop. Data in flight is discarded and no lane handshake completes in the clear cycle.
- Lane accept condition: lane_ok[ii] = ~lane_en_i[ii] | ~full[ii].
- stream_i.ready = &lane_ok, combinational from registered FIFO state and lane_en_i only. There is no combinational path from any stream_o.ready to stream_i.ready.
- Input handshake (valid & ready): every enabled lane pushes its slice; disabled lanes do not push.
- All lanes disabled: ready=1 and accepted beats are dropped.
- Push while full: blocked even if the same lane pops that cycle. This is deliberate, to avoid the ready path through the FIFO. Worst-case throughput is 1 beat per cycle with FIFO_DEPTH>=2.
- Output: stream_o[ii].valid = ~empty[ii]; data/strb = FIFO head. No fall-through, so latency from input handshake to lane valid is 1 cycle.
- Pop: stream_o[ii].valid & stream_o[ii].ready.
  - Simultaneous push and pop on a non-full lane: count unchanged, order preserved.
  - Push into an empty lane: head is visible next cycle.
- Disabled lanes: pops of already-queued entries continue regardless of lane_en_i. Toggling lane_en_i mid-stream affects only subsequent input beats.
- valid/data stability: lane outputs hold until popped (AXI-stream-like rule). A producer dropping stream_i.valid without handshake is tolerated; nothing is pushed.
- FIFO per lane:
  - Circular buffer, read/write pointers of $clog2(FIFO_DEPTH) bits (1 bit minimum).
  - Pointers wrap at FIFO_DEPTH-1 → 0, including non-power-of-two depths.
  - Occupancy counter of $clog2(FIFO_DEPTH+1) bits; full = (count==FIFO_DEPTH), empty = (count==0).

Decomposition:
- Shared package additions (hwpe_stream_package):
  - HWPE_STREAM_SPLIT_MIN_DEPTH = 1.
  - A lane_state_t enum {LANE_EMPTY, LANE_PARTIAL, LANE_FULL} used for assertions and coverage.
- Sub-module hwpe_stream_split_lane_fifo (DATA_WIDTH, FIFO_DEPTH):
  - One per lane, instantiated in a generate loop.
  - Ports: push/data/strb in, pop/data/strb out, full, empty, clk_i/rst_i/clear_i.
- Top-level: slicing, lane_ok reduction, busy_o.

Test Plan:
- NB=2, DW=128, depth 2, both lanes ready=1. Stream beats data=0x..0001..0002 for 8 cycles → each lane emits one slice per cycle, 1-cycle latency, stream_i.ready constantly 1.
- Lane1 ready=0, lane0 ready=1, push 3 beats → 2 beats accepted and stream_i.ready=0 at cycle 2. Lane0 emits both low slices; lane1 holds its head. Raise lane1 ready → lane1 emits 2 slices, ready returns, beat 3 accepted.
- lane_en_i=2'b01, push 4 beats with lane1 ready=0 → all 4 accepted over 4 cycles. Only lane0 emits; lane_empty_o[1] stays 1.
- lane_en_i=2'b00, push beat → ready=1, no lane valid, busy_o=0.
- Fill both lanes, assert clear_i one cycle with stream_i.valid=1 → next cycle lane_empty_o=2'b11, no valids, no push occurred.
- FIFO_DEPTH=3, single lane stalled then released → 6 push/pop cycles exercise pointer wrap 2→0; output order 1..6 preserved. Repeat with rst_i asserted mid-burst → all state empty next cycle.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// Shared definitions for the decoupled HWPE stream splitter.
//   HWPE_STREAM_SPLIT_MIN_DEPTH : smallest legal per-lane FIFO depth
//   lane_state_t                : coarse occupancy of one lane FIFO
//   lane_state()                : maps full/empty flags to lane_state_t
package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_SPLIT_MIN_DEPTH = 1;

  typedef enum logic [1:0] {
    LANE_EMPTY,
    LANE_PARTIAL,
    LANE_FULL
  } lane_state_t;

  function automatic lane_state_t lane_state(input logic full, input logic empty);
    if (empty)     return LANE_EMPTY;
    else if (full) return LANE_FULL;
    else           return LANE_PARTIAL;
  endfunction

endpackage

// File: rtl/hwpe_stream_split_lane_fifo.sv
// Per-lane circular FIFO for the decoupled stream splitter.
// No fall-through: a pushed entry becomes visible at data_o one cycle later.
// A push into a full FIFO is dropped even if a pop happens in the same cycle,
// which keeps the upstream ready free of any path from the lane ready.
//   clk_i, rst_i, clear_i : clock, sync active-high reset, sync soft clear
//   push_i, data_i, strb_i : write side
//   pop_i, data_o, strb_o  : read side (data_o/strb_o = head entry)
//   full_o, empty_o        : occupancy flags
module hwpe_stream_split_lane_fifo
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] strb_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_data [FIFO_DEPTH];
  logic [STRB_WIDTH-1:0] r_strb [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  lane_state_t w_state;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Clear discards everything, so nothing may complete in that cycle.
  assign w_push  = push_i & ~w_full  & ~clear_i;
  assign w_pop   = pop_i  & ~w_empty & ~clear_i;
  assign w_state = lane_state(w_full, w_empty);

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= data_i;
      r_strb[r_wr_ptr] <= strb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (r_count <= FULL_CNT);
      assert (!(w_state == LANE_FULL && w_push));
    end
  end

  assign data_o  = r_data[r_rd_ptr];
  assign strb_o  = r_strb[r_rd_ptr];
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

// File: rtl/hwpe_stream_split_decoupled.sv
// Splits one wide stream into NB_OUT_STREAMS narrow lanes, each buffered by
// its own FIFO so lanes drain independently. Lane ii carries slice ii of the
// input data/strb. Disabled lanes (lane_en_i=0) never push but keep draining.
//   clk_i, rst_i, clear_i   : clock, sync active-high reset, sync soft clear
//   lane_en_i               : per-lane enable, sampled every cycle
//   stream_i_*              : wide input stream (data/strb/valid/ready)
//   stream_o_*              : lane outputs, lane ii at slice ii of the flat buses
//   lane_empty_o, busy_o    : per-lane FIFO empty, OR of non-empty lanes
module hwpe_stream_split_decoupled
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_OUT_STREAMS = 2,
  parameter int unsigned DATA_WIDTH_IN  = 128,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic [NB_OUT_STREAMS-1:0]   lane_en_i,
  input  logic [DATA_WIDTH_IN-1:0]    stream_i_data,
  input  logic [DATA_WIDTH_IN/8-1:0]  stream_i_strb,
  input  logic                        stream_i_valid,
  output logic                        stream_i_ready,
  output logic [DATA_WIDTH_IN-1:0]    stream_o_data,
  output logic [DATA_WIDTH_IN/8-1:0]  stream_o_strb,
  output logic [NB_OUT_STREAMS-1:0]   stream_o_valid,
  input  logic [NB_OUT_STREAMS-1:0]   stream_o_ready,
  output logic [NB_OUT_STREAMS-1:0]   lane_empty_o,
  output logic                        busy_o
);

  localparam int unsigned DW_OUT = DATA_WIDTH_IN / NB_OUT_STREAMS;
  localparam int unsigned SW_OUT = DW_OUT / 8;

  if ((DATA_WIDTH_IN % (NB_OUT_STREAMS * 8)) != 0) begin : g_bad_width
    $error("DATA_WIDTH_IN must be divisible by NB_OUT_STREAMS*8");
  end
  if (FIFO_DEPTH < HWPE_STREAM_SPLIT_MIN_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least 1");
  end

  logic [NB_OUT_STREAMS-1:0] w_full;
  logic [NB_OUT_STREAMS-1:0] w_empty;
  logic [NB_OUT_STREAMS-1:0] w_lane_ok;
  logic [NB_OUT_STREAMS-1:0] w_push;
  logic                      w_in_hs;

  // Ready depends only on registered occupancy and the enable mask.
  assign w_lane_ok      = ~lane_en_i | ~w_full;
  assign stream_i_ready = &w_lane_ok;
  assign w_in_hs        = stream_i_valid & stream_i_ready;
  assign w_push         = {NB_OUT_STREAMS{w_in_hs}} & lane_en_i;

  for (genvar ii = 0; ii < NB_OUT_STREAMS; ii++) begin : g_lane
    hwpe_stream_split_lane_fifo #(
      .DATA_WIDTH (DW_OUT),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) i_lane_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .push_i  (w_push[ii]),
      .data_i  (stream_i_data[ii*DW_OUT +: DW_OUT]),
      .strb_i  (stream_i_strb[ii*SW_OUT +: SW_OUT]),
      .pop_i   (stream_o_ready[ii]),
      .data_o  (stream_o_data[ii*DW_OUT +: DW_OUT]),
      .strb_o  (stream_o_strb[ii*SW_OUT +: SW_OUT]),
      .full_o  (w_full[ii]),
      .empty_o (w_empty[ii])
    );
  end

  assign stream_o_valid = ~w_empty;
  assign lane_empty_o   = w_empty;
  assign busy_o         = |(~w_empty);

endmodule
